sobel_window_gen: RTL
=====================

# sobel_window_gen

Consumer-side companion to the two-line FIFO row buffer in the Sobel edge-detection path. Accepts the three vertically aligned row taps (current, one line back, two lines back) plus the buffer's ready/valid strobe, and assembles a sliding 3x3 pixel window with column/row position tracking and line/frame markers. Its output feeds the Sobel gradient kernel directly.

## Interface
Parameters:
- WIDTH, 640, pixels per image line; at least 3
- HEIGHT, 480, lines per frame; at least 3

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- valid_i  input  1  row taps valid this cycle (driven by the line buffer done strobe)
- data0_i  input  8  current-line pixel (bottom window row)
- data1_i  input  8  pixel one line back (middle row)
- data2_i  input  8  pixel two lines back (top row)
- window_o  output  72  3x3 window; byte p[r][c] is at bits [8*(3r+c)+7 : 8*(3r+c)]; r=0 top, c=2 newest column
- valid_o  output  1  window_o holds a new window this cycle
- col_o  output  clog2(WIDTH)  column of the newest window column
- row_o  output  clog2(HEIGHT)  output row index, 0..HEIGHT-3
- eol_o  output  1  pulses with valid_o on the last window of a line
- eof_o  output  1  pulses with valid_o on the last window of a frame

## Operation
- Window storage is a 3x3 array of 8-bit registers, one shift row per tap.
- On an accepted pixel (valid_i=1), each row shifts left: p[r][0]<=p[r][1], p[r][1]<=p[r][2], and p[r][2] loads the tap (r0<-data2_i, r1<-data1_i, r2<-data0_i).
- valid_i=0 is a bubble. All state holds, valid_o=0, and eol_o/eof_o=0.
- Column counter: increments on each accepted pixel and wraps WIDTH-1 -> 0.
- Row counter: increments on the column wrap and wraps HEIGHT-3 -> 0 at frame end.
- The first valid_i of a frame is column 0 of row 0, because the upstream buffer raises its strobe only once two lines are stored.
- State machine, two states:
  - FILL: waiting for columns 0 and 1 of a line.
  - STREAM: columns 2..WIDTH-1.
  - FILL->STREAM when an accepted pixel has column=1.
  - STREAM->FILL when an accepted pixel has column=WIDTH-1.
  - Reset enters FILL.
- Without the config macro, valid_o is asserted only for accepted pixels in STREAM (column>=2). That gives WIDTH-2 windows per line and (WIDTH-2)*(HEIGHT-2) per frame.
- eol_o is asserted when the accepted column is WIDTH-1.
- eof_o is asserted when eol_o is set and row = HEIGHT-3.
- Reset mid-frame clears all window registers, counters and FSM immediately. The next valid_i is treated as column 0, row 0.

## Timing
- Latency is one cycle. A pixel accepted at edge N is visible at p[*][2], with valid_o/col_o/row_o/eol_o/eof_o, after edge N.
- All outputs are registered. valid_o/eol_o/eof_o are single-cycle pulses per accepted pixel.
- Back-to-back valid_i sustains one window per cycle. There is no backpressure, so the downstream block must accept every valid_o.
- Reset values:
  - window_o=0, valid_o=0, col_o=0, row_o=0, eol_o=0, eof_o=0
  - FSM=FILL
- Counter arithmetic is unsigned. Wrap compares are against WIDTH-1 and HEIGHT-3 exactly, with no overflow past those bounds.
- A bubble on the eol cycle defers the wrap until the pixel is actually accepted.

## Configuration
- Macro: SOBEL_WINDOW_ZERO_PAD_EN.
- Defined:
  - Every accepted pixel produces valid_o, WIDTH windows per line, including columns 0 and 1.
  - At column 0 the shift loads p[r][2] and forces p[r][0]=p[r][1]=0.
  - At column 1 it shifts normally, and p[r][0] remains 0.
  - Left-border windows are therefore zero-padded. The FSM still runs but does not gate valid_o.
- Undefined: behaviour is as described in Operation, with no border windows.

## Test plan
- Reset then idle: hold rst=0 for 3 cycles, release, valid_i=0 for 10 cycles -> all outputs 0 throughout.
- Single line, WIDTH=8, HEIGHT=4:
  - Stimulus: feed data0_i=col, data1_i=16+col, data2_i=32+col for col 0..7 back-to-back.
  - Required: 6 valid_o pulses at col_o=2..7.
  - At col_o=2, window_o bytes p[0][0..2]=32,33,34, p[1][0..2]=16,17,18, p[2][0..2]=0,1,2.
  - eol_o only at col_o=7.
- Full frame, WIDTH=8, HEIGHT=4: 16 accepted pixels -> 12 windows, row_o 0 then 1, eof_o once at row_o=1/col_o=7, then counters back to 0/0.
- Bubbles: insert valid_i=0 every other cycle in one line -> the same window contents and count as the back-to-back run, valid_o never set on a bubble cycle.
- Reset mid-line: assert rst at column 4, release, feed a new line -> the first window at col_o=2 contains only post-reset pixels and row_o=0.
- With SOBEL_WINDOW_ZERO_PAD_EN, WIDTH=8:
  - Required: 8 windows per line.
  - At col_o=0, p[r][0]=p[r][1]=0 with p[2][2]=0.
  - At col_o=1, p[r][0]=0.
  - eol_o at col_o=7.

Source files
------------

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: assembles a sliding 3x3 window from three row taps with column/row/eol/eof tracking.
// Define SOBEL_WINDOW_ZERO_PAD_EN to also emit zero-padded left-border windows at columns 0 and 1.
module sobel_window_gen #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    input  logic [7:0]                data0_i,
    input  logic [7:0]                data1_i,
    input  logic [7:0]                data2_i,
    output logic [71:0]               window_o,
    output logic                      valid_o,
    output logic [$clog2(WIDTH)-1:0]  col_o,
    output logic [$clog2(HEIGHT)-1:0] row_o,
    output logic                      eol_o,
    output logic                      eof_o
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    typedef enum logic {FILL, STREAM} state_t;

    state_t               r_state;
    logic [2:0][2:0][7:0] r_p;
    logic [CW-1:0]        r_col, r_col_o;
    logic [RW-1:0]        r_row, r_row_o;
    logic                 r_valid, r_eol, r_eof;
    logic                 w_last_col, w_last_row, w_border, w_emit;

    assign w_last_col = r_col == CW'(WIDTH - 1);
    assign w_last_row = r_row == RW'(HEIGHT - 3);
`ifdef SOBEL_WINDOW_ZERO_PAD_EN
    assign w_border = r_col == '0;
    assign w_emit   = 1'b1;
`else
    assign w_border = 1'b0;
    assign w_emit   = r_state == STREAM;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FILL;
            r_p     <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_col_o <= '0;
            r_row_o <= '0;
            r_valid <= 1'b0;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;
            if (valid_i) begin
                // top row takes the oldest line, bottom row the current line
                r_p[0]  <= w_border ? {data2_i, 16'd0} : {data2_i, r_p[0][2:1]};
                r_p[1]  <= w_border ? {data1_i, 16'd0} : {data1_i, r_p[1][2:1]};
                r_p[2]  <= w_border ? {data0_i, 16'd0} : {data0_i, r_p[2][2:1]};
                r_col_o <= r_col;
                r_row_o <= r_row;
                r_valid <= w_emit;
                r_eol   <= w_last_col;
                r_eof   <= w_last_col && w_last_row;
                r_col   <= w_last_col ? '0 : r_col + CW'(1);
                if (w_last_col)
                    r_row <= w_last_row ? '0 : r_row + RW'(1);
                if (r_col == CW'(1))
                    r_state <= STREAM;
                else if (w_last_col)
                    r_state <= FILL;
            end
        end
    end

    assign window_o = r_p;
    assign valid_o  = r_valid;
    assign col_o    = r_col_o;
    assign row_o    = r_row_o;
    assign eol_o    = r_eol;
    assign eof_o    = r_eof;
endmodule
